// File: rtl/pi_switch_xbar_0.sv
// pi_switch_xbar_0: 4x4 registered packet crossbar with saturating per-output valid-packet counters.
// Define PI_XBAR_LFSR_EN to source `random` from an 8-bit Fibonacci LFSR instead of a toggle flop.
`ifndef LEFT
`define LEFT 2'd0
`endif
`ifndef RIGHT
`define RIGHT 2'd1
`endif
`ifndef UPL
`define UPL 2'd2
`endif
`ifndef UPR
`define UPR 2'd3
`endif

module pi_switch_xbar_0 #(
   parameter int P_W   = 49,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [P_W-1:0]   l_bus_i,
   input  logic [P_W-1:0]   r_bus_i,
   input  logic [P_W-1:0]   ul_bus_i,
   input  logic [P_W-1:0]   ur_bus_i,
   input  logic [1:0]       sel_l,
   input  logic [1:0]       sel_r,
   input  logic [1:0]       sel_ul,
   input  logic [1:0]       sel_ur,
   input  logic             rand_gen,
   input  logic             cnt_clr,
   output logic             random,
   output logic [P_W-1:0]   l_bus_o,
   output logic [P_W-1:0]   r_bus_o,
   output logic [P_W-1:0]   ul_bus_o,
   output logic [P_W-1:0]   ur_bus_o,
   output logic [CNT_W-1:0] cnt_l,
   output logic [CNT_W-1:0] cnt_r,
   output logic [CNT_W-1:0] cnt_ul,
   output logic [CNT_W-1:0] cnt_ur
);

   logic [P_W-1:0] l_nxt_s;
   logic [P_W-1:0] r_nxt_s;
   logic [P_W-1:0] ul_nxt_s;
   logic [P_W-1:0] ur_nxt_s;

   function automatic logic [P_W-1:0] pick(input logic [1:0] sel,
                                           input logic [P_W-1:0] l, input logic [P_W-1:0] r,
                                           input logic [P_W-1:0] ul, input logic [P_W-1:0] ur);
      case (sel)
         `LEFT:   pick = l;
         `RIGHT:  pick = r;
         `UPL:    pick = ul;
         `UPR:    pick = ur;
         default: pick = ur;
      endcase
   endfunction

   // Counter step: clear wins, then count valid packets, holding at all-ones.
   function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                  input logic vld, input logic clr);
      if (clr) begin
         cnt_step = {CNT_W{1'b0}};
      end else if (vld && (cnt != {CNT_W{1'b1}})) begin
         cnt_step = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_step = cnt;
      end
   endfunction

   // Source selection for each output port.
   always_comb begin
      l_nxt_s  = pick(sel_l,  l_bus_i, r_bus_i, ul_bus_i, ur_bus_i);
      r_nxt_s  = pick(sel_r,  l_bus_i, r_bus_i, ul_bus_i, ur_bus_i);
      ul_nxt_s = pick(sel_ul, l_bus_i, r_bus_i, ul_bus_i, ur_bus_i);
      ur_nxt_s = pick(sel_ur, l_bus_i, r_bus_i, ul_bus_i, ur_bus_i);
   end

   // Output packet registers; void packets pass through untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l_bus_o  <= {P_W{1'b0}};
         r_bus_o  <= {P_W{1'b0}};
         ul_bus_o <= {P_W{1'b0}};
         ur_bus_o <= {P_W{1'b0}};
      end else begin
         l_bus_o  <= l_nxt_s;
         r_bus_o  <= r_nxt_s;
         ul_bus_o <= ul_nxt_s;
         ur_bus_o <= ur_nxt_s;
      end
   end

   // Per-output counters track the valid flag of the packet being loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_l  <= {CNT_W{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
         cnt_ul <= {CNT_W{1'b0}};
         cnt_ur <= {CNT_W{1'b0}};
      end else begin
         cnt_l  <= cnt_step(cnt_l,  l_nxt_s[P_W-1],  cnt_clr);
         cnt_r  <= cnt_step(cnt_r,  r_nxt_s[P_W-1],  cnt_clr);
         cnt_ul <= cnt_step(cnt_ul, ul_nxt_s[P_W-1], cnt_clr);
         cnt_ur <= cnt_step(cnt_ur, ur_nxt_s[P_W-1], cnt_clr);
      end
   end

`ifdef PI_XBAR_LFSR_EN
   logic [7:0] lfsr_r;
   logic [7:0] lfsr_nxt_s;

   // x^8+x^6+x^5+x^4+1, shifting toward the MSB.
   always_comb begin
      lfsr_nxt_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
   end

   // random is its own flop so it can reset to 0 while the LFSR seeds to 8'h01.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_r <= 8'h01;
         random <= 1'b0;
      end else if (rand_gen) begin
         lfsr_r <= lfsr_nxt_s;
         random <= lfsr_nxt_s[0];
      end else begin
         lfsr_r <= lfsr_r;
         random <= random;
      end
   end
`else
   // Toggle tie-break bit advanced on arbiter request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         random <= 1'b0;
      end else if (rand_gen) begin
         random <= ~random;
      end else begin
         random <= random;
      end
   end
`endif

endmodule

// File: tb/tb_pi_switch_xbar_0.sv
// Randomized bench for pi_switch_xbar_0 against a behavioural crossbar/counter/random model.
`ifndef LEFT
`define LEFT 2'd0
`endif
`ifndef RIGHT
`define RIGHT 2'd1
`endif
`ifndef UPL
`define UPL 2'd2
`endif
`ifndef UPR
`define UPR 2'd3
`endif

module tb_pi_switch_xbar_0;
   localparam int PW = 49;
   localparam int CW = 4;
   localparam int CMAX = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] in_bus [4];
   logic [1:0]    sel [4];
   logic          rand_gen;
   logic          cnt_clr;
   logic          random;
   logic [PW-1:0] out_bus [4];
   logic [CW-1:0] cnt [4];

   logic [PW-1:0] exp_bus [4];
   int            exp_cnt [4];
   logic          exp_rand;
   logic [7:0]    lfsr_m;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   pi_switch_xbar_0 #(.P_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .l_bus_i(in_bus[0]), .r_bus_i(in_bus[1]), .ul_bus_i(in_bus[2]), .ur_bus_i(in_bus[3]),
      .sel_l(sel[0]), .sel_r(sel[1]), .sel_ul(sel[2]), .sel_ur(sel[3]),
      .rand_gen(rand_gen), .cnt_clr(cnt_clr), .random(random),
      .l_bus_o(out_bus[0]), .r_bus_o(out_bus[1]), .ul_bus_o(out_bus[2]), .ur_bus_o(out_bus[3]),
      .cnt_l(cnt[0]), .cnt_r(cnt[1]), .cnt_ul(cnt[2]), .cnt_ur(cnt[3])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else passes++;
   endtask

   function automatic int src_of(input logic [1:0] s);
      case (s)
         `LEFT:   return 0;
         `RIGHT:  return 1;
         `UPL:    return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 4; p++) begin
         exp_bus[p] = '0;
         exp_cnt[p] = 0;
      end
      exp_rand = 1'b0;
      lfsr_m = 8'h01;
   endtask

   task automatic compare_all();
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("bus%0d", p), 64'(out_bus[p]), 64'(exp_bus[p]));
         chk($sformatf("cnt%0d", p), 64'(cnt[p]), 64'(exp_cnt[p]));
      end
      chk("random", 64'(random), 64'(exp_rand));
   endtask

   // Predict the next state from the rules, cross one edge, then compare.
   task automatic step();
      logic fb;
      for (int p = 0; p < 4; p++) begin
         exp_bus[p] = in_bus[src_of(sel[p])];
         if (cnt_clr) exp_cnt[p] = 0;
         else if (exp_bus[p][PW-1] && exp_cnt[p] < CMAX) exp_cnt[p] = exp_cnt[p] + 1;
      end
      if (rand_gen) begin
`ifdef PI_XBAR_LFSR_EN
         fb = lfsr_m[8-1] ^ lfsr_m[6-1] ^ lfsr_m[5-1] ^ lfsr_m[4-1];
         lfsr_m = {lfsr_m[6:0], fb};
         exp_rand = lfsr_m[0];
`else
         fb = 1'b0;
         exp_rand = ~exp_rand;
`endif
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic mid_reset();
      reset = 1'b0;
      #2;
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("rst_bus%0d", p), 64'(out_bus[p]), 64'd0);
         chk($sformatf("rst_cnt%0d", p), 64'(cnt[p]), 64'd0);
      end
      chk("rst_random", 64'(random), 64'd0);
      model_reset();
      reset = 1'b1;
      #1;
   endtask

   task automatic quiet_inputs();
      for (int p = 0; p < 4; p++) begin
         in_bus[p] = '0;
         sel[p] = `LEFT;
      end
      rand_gen = 1'b0;
      cnt_clr = 1'b0;
   endtask

   initial begin
      logic [PW-1:0] pa, pb, pc, pd;
      logic [7:0] gen_seq, exp_seq;
      int seq_len;

      reset = 1'b0;
      quiet_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      reset = 1'b1;

      // Straight-through on L, other outputs fed from a void source.
      in_bus[0] = 49'h1_0000_0000_00AA;
      sel[0] = `LEFT; sel[1] = `RIGHT; sel[2] = `RIGHT; sel[3] = `RIGHT;
      step();
      chk("lit_straight_bus", 64'(out_bus[0]), 64'h1_0000_0000_00AA);
      chk("lit_straight_cnt", 64'(cnt[0]), 64'd1);
      chk("lit_straight_cnt_r", 64'(cnt[1]), 64'd0);

      // Full permutation of four valid packets.
      pa = 49'h1_0000_0000_0A0A; pb = 49'h1_0000_0000_0B0B;
      pc = 49'h1_0000_0000_0C0C; pd = 49'h1_0000_0000_0D0D;
      in_bus[0] = pa; in_bus[1] = pb; in_bus[2] = pc; in_bus[3] = pd;
      sel[0] = `UPR; sel[1] = `UPL; sel[2] = `RIGHT; sel[3] = `LEFT;
      step();
      chk("lit_perm_l", 64'(out_bus[0]), 64'(pd));
      chk("lit_perm_r", 64'(out_bus[1]), 64'(pc));
      chk("lit_perm_ul", 64'(out_bus[2]), 64'(pb));
      chk("lit_perm_ur", 64'(out_bus[3]), 64'(pa));
      chk("lit_perm_cnt_l", 64'(cnt[0]), 64'd2);
      chk("lit_perm_cnt_ur", 64'(cnt[3]), 64'd1);

      // Random-bit sequence with void traffic.
      quiet_inputs();
`ifdef PI_XBAR_LFSR_EN
      gen_seq = 8'b1111_1111; exp_seq = 8'b0011_1000; seq_len = 8;
`else
      gen_seq = 8'b0000_0111; exp_seq = 8'b0001_1101; seq_len = 5;
`endif
      for (int i = 0; i < seq_len; i++) begin
         rand_gen = gen_seq[i];
         step();
         chk($sformatf("lit_random_%0d", i), 64'(random), 64'(exp_seq[i]));
      end
      rand_gen = 1'b0;

      // Saturation on UL, then clear racing a valid packet.
      in_bus[2] = 49'h1_0000_0000_5555;
      sel[2] = `UPL;
      for (int i = 0; i < 20; i++) step();
      chk("lit_sat_cnt_ul", 64'(cnt[2]), 64'd15);
      cnt_clr = 1'b1;
      step();
      chk("lit_clr_cnt_ul", 64'(cnt[2]), 64'd0);
      cnt_clr = 1'b0;

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < 4; p++) begin
            in_bus[p] = {($urandom_range(0, 3) != 0), 16'($urandom), 32'($urandom)};
            sel[p] = 2'($urandom_range(0, 3));
         end
         rand_gen = 1'($urandom_range(0, 1));
         cnt_clr = ($urandom_range(0, 39) == 0);
         step();
         if (i == 100 || $urandom_range(0, 99) == 0) mid_reset();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/pi_switch_xbar_0.md
PI_SWITCH_XBAR_0 -- requirements
Module: pi_switch_xbar_0

Interface
REQ-001 The block SHALL have parameter P_W, default 49, meaning packet width in bits, where bit P_W-1 is the valid flag.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each per-port packet counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 l_bus_i, r_bus_i, ul_bus_i, ur_bus_i  input  P_W each  packets arriving on the L, R, UL and UR ports.
REQ-007 sel_l, sel_r, sel_ul, sel_ur  input  2 each  per-output source select from the pi arbiter.
  - Encodings: `LEFT, `RIGHT, `UPL, `UPR from direction_params.vh.
REQ-008 rand_gen  input  1  arbiter request to advance the random/toggle bit.
REQ-009 cnt_clr  input  1  synchronous clear of all packet counters.
REQ-010 random  output  1  registered tie-break bit; feeds the arbiter's random input.
REQ-011 l_bus_o, r_bus_o, ul_bus_o, ur_bus_o  output  P_W each  registered output packets.
REQ-012 cnt_l, cnt_r, cnt_ul, cnt_ur  output  CNT_W each  count of valid packets emitted per output port.

Function
REQ-013 Each output register SHALL load, every cycle, the input bus named by its select: `LEFT->l_bus_i, `RIGHT->r_bus_i, `UPL->ul_bus_i, `UPR->ur_bus_i.
REQ-014 Latency from input bus/select to output bus SHALL be exactly 1 clk cycle; the block has no stall or backpressure.
REQ-015 Two or more outputs selecting the same source SHALL all receive that source's packet (duplication permitted; the arbiter guarantees this occurs only for void packets).
REQ-016 random SHALL change only on a rising edge with rand_gen=1, and SHALL hold when rand_gen=0.
REQ-017 The arbiter's combinational path SHALL use the current registered random value; no combinational path from any input to random is permitted.
REQ-018 cnt_X SHALL increment by 1 on each edge at which the value loaded into X_bus_o has bit P_W-1 = 1.
REQ-019 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-020 cnt_clr=1 SHALL zero all four counters on the next edge; clear takes priority over a simultaneous increment.
REQ-021 A void input packet (bit P_W-1 = 0) SHALL be forwarded unmodified, including its payload bits, and SHALL NOT count.

Reset
REQ-022 Asserting reset (low) SHALL immediately force all X_bus_o to 0, all cnt_X to 0, and random to 0, regardless of clk.
REQ-023 In LFSR mode, asserting reset SHALL force the LFSR state to 8'h01.
REQ-024 Reset asserted mid-traffic SHALL discard in-flight packets.
REQ-025 After release, the first edge SHALL load outputs normally; no warm-up cycles are permitted.

Configuration
REQ-026 Macro PI_XBAR_LFSR_EN SHALL select the random source.
REQ-027 With PI_XBAR_LFSR_EN undefined, random SHALL be a toggle flip-flop that inverts on each edge with rand_gen=1.
REQ-028 With PI_XBAR_LFSR_EN defined, random SHALL be bit 0 of an 8-bit Fibonacci LFSR.
  - Taps: x^8+x^6+x^5+x^4+1.
  - Seed: 8'h01.
  - Shifts one step on each edge with rand_gen=1.
REQ-029 Neither configuration SHALL change the ports, the datapath, or the counter behaviour.

Verification
REQ-030 Straight-through: l_bus_i=valid 0x1_0000_0000_00AA, sel_l=`LEFT, other sels void sources -> l_bus_o equals the input one cycle later; cnt_l=1.
REQ-031 Full permutation: four valid packets with sel_l=`UPR, sel_r=`UPL, sel_ul=`RIGHT, sel_ur=`LEFT -> each output carries the mapped packet after 1 cycle; each counter increments by 1.
REQ-032 Toggle mode: rand_gen=1 for 3 edges, then 0 for 2 edges -> random sequence 1,0,1,1,1.
REQ-033 LFSR mode: rand_gen=1 from reset for 8 edges -> random matches the reference LFSR model bit for bit.
REQ-034 Saturation and clear: CNT_W=4 with 20 valid packets on UL -> cnt_ul holds at 15; cnt_clr pulsed with a simultaneous valid packet -> cnt_ul=0.
REQ-035 Reset mid-traffic: reset driven low between edges while outputs are valid -> outputs, counters and random read 0 before the next clk edge.
